// File: rtl/display_axi_rd_arb.sv
// Two-requester AXI read arbiter for display fetch. One burst is outstanding
// at a time; requesters are served round-robin and read data is routed back
// only to the requester that owns the port.
module display_axi_rd_arb #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 64
) (
    input  logic                      pixel_clk,
    input  logic                      rst,

    input  logic [AXI_ADDR_WIDTH-1:0] s0_araddr,
    input  logic [7:0]                s0_arlen,
    input  logic                      s0_arvalid,
    output logic                      s0_arready,
    output logic [AXI_DATA_WIDTH-1:0] s0_rdata,
    output logic [1:0]                s0_rresp,
    output logic                      s0_rvalid,
    input  logic                      s0_rready,

    input  logic [AXI_ADDR_WIDTH-1:0] s1_araddr,
    input  logic [7:0]                s1_arlen,
    input  logic                      s1_arvalid,
    output logic                      s1_arready,
    output logic [AXI_DATA_WIDTH-1:0] s1_rdata,
    output logic [1:0]                s1_rresp,
    output logic                      s1_rvalid,
    input  logic                      s1_rready,

    output logic [AXI_ADDR_WIDTH-1:0] m_araddr,
    output logic [7:0]                m_arlen,
    output logic [2:0]                m_arsize,
    output logic [1:0]                m_arburst,
    output logic                      m_arvalid,
    input  logic                      m_arready,
    input  logic [AXI_DATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]                m_rresp,
    input  logic                      m_rlast,
    input  logic                      m_rvalid,
    output logic                      m_rready,

    output logic                      busy,
    output logic                      grant_id,
    output logic                      err,
    input  logic                      err_clr
);

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    state_e                    state_q, state_d;
    logic                      grant_q, grant_d;
    logic                      last_q, last_d;
    logic                      err_q, err_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]                len_q, len_d;
    logic [7:0]                cnt_q, cnt_d;

    logic any_req;
    logic win;
    logic in_data;
    logic beat;
    logic beat_err;

    // Round-robin winner: a lone request wins, a tie goes to the one not served last.
    always_comb begin
        any_req = s0_arvalid | s1_arvalid;
        if (s0_arvalid && s1_arvalid) begin
            win = ~last_q;
        end else begin
            win = ~s0_arvalid;
        end
    end

    // Beat transfer and protocol-error detection against the remaining-beat counter.
    always_comb begin
        in_data  = (state_q == StData);
        beat     = in_data && m_rvalid && m_rready;
        beat_err = beat && ((m_rresp != 2'b00) ||
                            (m_rlast && (cnt_q != 8'd0)) ||
                            (!m_rlast && (cnt_q == 8'd0)));
    end

    // Next-state logic for the burst FSM and its datapath registers.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    grant_d = win;
                    addr_d  = win ? s1_araddr : s0_araddr;
                    len_d   = win ? s1_arlen : s0_arlen;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (m_arready) begin
                    cnt_d   = len_q;
                    state_d = StData;
                end
            end
            StData: begin
                if (beat) begin
                    if (cnt_q != 8'd0) begin
                        cnt_d = cnt_q - 8'd1;
                    end
                    // Only rlast ends the burst, even if the count disagrees.
                    if (m_rlast) begin
                        last_d  = grant_q;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        // A new error wins over a simultaneous clear.
        if (beat_err) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            err_q   <= 1'b0;
            addr_q  <= '0;
            len_q   <= 8'd0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake outputs; arready is gated by rst so it is low during reset.
    always_comb begin
        s0_arready = (state_q == StIdle) && any_req && !rst && !win;
        s1_arready = (state_q == StIdle) && any_req && !rst && win;
        m_arvalid  = (state_q == StAddr);
        m_rready   = in_data && (grant_q ? s1_rready : s0_rready);
        s0_rvalid  = in_data && m_rvalid && !grant_q;
        s1_rvalid  = in_data && m_rvalid && grant_q;
    end

    assign s0_rdata  = m_rdata;
    assign s1_rdata  = m_rdata;
    assign s0_rresp  = m_rresp;
    assign s1_rresp  = m_rresp;
    assign m_araddr  = addr_q;
    assign m_arlen   = len_q;
    assign m_arsize  = 3'd3;
    assign m_arburst = 2'd1;
    assign busy      = (state_q != StIdle);
    assign grant_id  = grant_q;
    assign err       = err_q;

endmodule

// File: doc/display_axi_rd_arb.md
DISPLAY_AXI_RD_ARB -- requirements
Module: display_axi_rd_arb

Interface
REQ-001 Parameter AXI_ADDR_WIDTH, default 32, address width of all AR channels.
REQ-002 Parameter AXI_DATA_WIDTH, default 64, data width of all R channels.
REQ-003 pixel_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 s{0,1}_araddr  input  AXI_ADDR_WIDTH  requester burst start address.
REQ-006 s{0,1}_arlen  input  8  requester burst length minus one.
REQ-007 s{0,1}_arvalid  input  1  requester read request valid.
REQ-008 s{0,1}_arready  output  1  request accepted by arbiter.
REQ-009 s{0,1}_rdata  output  AXI_DATA_WIDTH  read data, broadcast copy of m_rdata.
REQ-010 s{0,1}_rresp  output  2  read response, broadcast copy of m_rresp.
REQ-011 s{0,1}_rvalid  output  1  read beat valid for this requester.
REQ-012 s{0,1}_rready  input  1  requester can take a beat.
REQ-013 m_araddr/m_arlen  output  AXI_ADDR_WIDTH/8  latched granted request.
REQ-014 m_arsize  output  3  constant 3'd3; m_arburst  output  2  constant 2'd1 (INCR).
REQ-015 m_arvalid  output  1; m_arready  input  1  shared AXI read address handshake.
REQ-016 m_rdata  input  AXI_DATA_WIDTH; m_rresp  input  2; m_rlast  input  1; m_rvalid  input  1; m_rready  output  1.
REQ-017 busy  output  1  high whenever state is not IDLE.
REQ-018 grant_id  output  1  index of the requester currently owning the port.
REQ-019 err  output  1  sticky error flag; err_clr  input  1  synchronous clear pulse.

Function
REQ-020 FSM states: IDLE, ADDR, DATA; exactly one burst outstanding at any time.
REQ-021 IDLE: if any sN_arvalid, select the winner combinationally, assert its sN_arready for exactly that cycle, latch its araddr/arlen into m_araddr/m_arlen, set grant_id, and move to ADDR.
REQ-022 Arbitration is round-robin: a single request wins; with both requesting, the requester not served last wins; the last-served pointer resets to 1, so requester 0 wins first after reset.
REQ-023 ADDR: m_arvalid=1 with stable address and length; on m_arready, load beat counter with m_arlen and move to DATA; m_arvalid=0 from the next cycle.
REQ-024 DATA: sN_rvalid = m_rvalid for the granted N only, 0 for the other; m_rready = granted sN_rready; a beat transfers when m_rvalid && m_rready.
REQ-025 Each transferred beat decrements the beat counter; the counter does not wrap below 0.
REQ-026 A beat with m_rlast=1 ends the burst: update the last-served pointer to grant_id and return to IDLE on the next edge; no new grant occurs in that same cycle.
REQ-027 Minimum turnaround from IDLE grant to m_arvalid is 1 cycle; back-to-back bursts are separated by 1 IDLE cycle.
REQ-028 err sets on any transferred beat with m_rresp!=2'b00, or with m_rlast=1 while the counter is not 0, or with m_rlast=0 while the counter is 0; the burst still ends only on m_rlast.
REQ-029 err_clr clears err; if err_clr and a new error occur in the same cycle, err stays set.
REQ-030 Requester deasserting sN_arvalid after acceptance has no effect; the latched request completes.
REQ-031 m_rvalid while not in DATA is ignored: m_rready=0 and no sN_rvalid.

Reset
REQ-032 When rst is asserted, including mid-burst: state=IDLE, m_arvalid=0, m_rready=0, sN_arready=0, sN_rvalid=0, busy=0, grant_id=0, err=0, m_araddr=0, m_arlen=0, counter=0, last-served pointer=1.
REQ-033 Outputs take their reset values asynchronously; the first grant is possible on the first edge after rst deasserts.

Verification
REQ-034 s0 only, araddr=0x1000_0000, arlen=15, m_arready=1, 16 beats with rlast on beat 16 -> s0_arready one pulse, m_araddr=0x1000_0000, m_arlen=15, 16 s0_rvalid beats, s1_rvalid=0, busy low afterward, err=0.
REQ-035 s0 and s1 request continuously with arlen=3 -> grants alternate 0,1,0,1 and each s1 burst returns 4 beats only on s1_rvalid.
REQ-036 During DATA hold s0_rready=0 for 5 cycles with m_rvalid=1 -> m_rready=0 in those cycles, the beat count is unchanged, and no beat is lost.
REQ-037 arlen=3 with rlast on beat 2, then m_rresp=2'b10 in a later burst -> err sets at the first case, the burst ends on beat 2, and err_clr returns err to 0.
REQ-038 Assert rst during beat 5 of a 16-beat burst -> all outputs reach their reset values immediately; after release, a pending s1 request is granted cleanly.
